uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Byte FIFO between UART_reciever and UART_buffer/UART_transmitter. Absorbs bursts of received bytes so the transmit side can drain at its own pace. Write side takes the receiver's one-cycle ready strobe and byte. Read side is a request/strobe interface that matches the codebase's ready_out style.

Parameters:
M, 8, byte width in bits
DEPTH, 16, number of entries; power of two, minimum 2
CW, $clog2(DEPTH+1), width of count output (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
wr_en  input  1  write strobe, driven by receiver ready_out
byte_in  input  M  data written when wr_en=1
rd_en  input  1  read request from downstream
byte_out  output  M  read data, registered
ready_out  output  1  one-cycle strobe: byte_out holds the popped byte
empty  output  1  no entries stored
full  output  1  DEPTH entries stored
count  output  CW  number of stored entries, 0..DEPTH
overflow  output  1  sticky: a write was dropped

Behaviour:
- Storage: DEPTH x M array.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
- Occupancy: count register tracks the number of stored entries, and full/empty are decoded from it.
- Reset (reset=0, async): wr_ptr=0, rd_ptr=0, count=0, byte_out=0, ready_out=0, overflow=0, so empty=1 and full=0. Array contents are not reset.
- Reset mid-operation discards all stored data immediately; no ready_out is issued after reset deassert until a new read is accepted.
- Write accept rule: wr_acc = wr_en & (~full | rd_acc).
  - On accept: mem[wr_ptr]<=byte_in, wr_ptr++.
- Read accept rule: rd_acc = rd_en & ~empty.
  - On accept: byte_out<=mem[rd_ptr], rd_ptr++, ready_out<=1 next cycle. Otherwise ready_out<=0.
  - byte_out holds its last value when no read is accepted.
- Read latency: 1 cycle from rd_en to ready_out/byte_out.
- Write-to-read latency: a byte written in cycle N is readable (empty=0) from cycle N+1.
- Count update: count += wr_acc - rd_acc. Simultaneous accepted read and write leaves count unchanged.
- Full + wr_en + rd_en: both accepted. The new byte goes into the freed slot, full stays 1.
- Full + wr_en, no rd_en: write dropped, overflow<=1 (sticky until reset), contents unchanged.
- Empty + wr_en + rd_en: write accepted, read ignored (no bypass), ready_out=0, count becomes 1.
- Empty + rd_en alone: ignored, ready_out=0, no pointer change, overflow unaffected.
- rd_en held high continuously: one pop per cycle while non-empty, giving back-to-back ready_out strobes.
- No state machine beyond pointers and count. Outputs empty/full are combinational from count; all other outputs are registered.

Optional Feature:
Macro: UART_RX_FIFO_ALMOST_FULL_EN
- Defined:
  - Adds parameter AF_LEVEL (default DEPTH-2) and output almost_full (1 bit, registered).
  - almost_full=1 whenever the next-state count >= AF_LEVEL, updated the same cycle as count. Reset value is 0.
  - Used upstream as a flow-control hint.
- Not defined: neither the port nor the parameter exists; behaviour is otherwise identical.

Test Plan:
1. Reset then idle 10 cycles -> empty=1, full=0, count=0, ready_out=0, byte_out=8'h00, overflow=0. Assert reset=0 mid-run with 5 entries stored -> count=0 and empty=1 asynchronously, before the next clock edge.
2. Write 8'hA5, 8'h3C, 8'h0F on consecutive cycles, then rd_en high for 4 cycles -> ready_out pulses 3 times with byte_out A5, 3C, 0F in order. The 4th request is ignored, and empty=1 at the end.
3. Write 16 bytes 8'h00..8'h0F (DEPTH=16) -> full=1, count=16. A 17th write of 8'hFF -> dropped, overflow=1. Then read 16 -> data 00..0F with no FF, and overflow stays 1.
4. When full, wr_en=1 with byte 8'h77 and rd_en=1 in the same cycle -> pop returns 8'h00, count stays 16, overflow=0. After draining, the last byte read is 8'h77.
5. When empty, wr_en=1 with 8'h5A and rd_en=1 in the same cycle -> ready_out=0, count=1. rd_en next cycle -> ready_out=1, byte_out=8'h5A.
6. Wrap-around: 40 interleaved write/read pairs with incrementing data, then with UART_RX_FIFO_ALMOST_FULL_EN defined fill to 14 entries -> data is in order across pointer wrap, and almost_full rises exactly when count reaches 14.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the UART receiver and the transmit side: strobe write, request/strobe read.
// Optional registered almost_full output enabled by defining UART_RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo #(
    parameter int unsigned M     = 8,
    parameter int unsigned DEPTH = 16,
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    parameter int unsigned AF_LEVEL = DEPTH - 2,
`endif
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [M-1:0]  byte_in,
    input  logic          rd_en,
    output logic [M-1:0]  byte_out,
    output logic          ready_out,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    output logic          almost_full,
`endif
    output logic          overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [M-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [M-1:0]  byte_out_q, byte_out_d;
    logic          ready_out_q, ready_out_d;
    logic          overflow_q, overflow_d;
    logic          wr_acc, rd_acc;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        byte_out_d  = byte_out_q;
        ready_out_d = rd_acc;
        overflow_d  = overflow_q;
        count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            byte_out_d = mem_q[rd_ptr_q];
        end
        if (wr_en && !wr_acc) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            byte_out_q  <= '0;
            ready_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            byte_out_q  <= byte_out_d;
            ready_out_q <= ready_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is intentionally not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= byte_in;
        end
    end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    logic almost_full_q, almost_full_d;

    assign almost_full_d = (32'(count_d) >= AF_LEVEL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end

    assign almost_full = almost_full_q;
`endif

    assign byte_out  = byte_out_q;
    assign ready_out = ready_out_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int unsigned M     = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [M-1:0]  byte_in = '0;
    logic          rd_en = 1'b0;
    logic [M-1:0]  byte_out;
    logic          ready_out;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    logic          almost_full;
`endif

    uart_rx_fifo #(
        .M     (M),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .byte_in     (byte_in),
        .rd_en       (rd_en),
        .byte_out    (byte_out),
        .ready_out   (ready_out),
        .empty       (empty),
        .full        (full),
        .count       (count),
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
        .almost_full (almost_full),
`endif
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;

    // Reference model: a plain queue of stored bytes plus the registered outputs it implies.
    logic [M-1:0]  model_q [$];
    logic [M-1:0]  exp_byte;
    logic          exp_ready;
    logic          exp_ovf;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("ready_out", 32'(ready_out), 32'(exp_ready));
        check_val("byte_out", 32'(byte_out), 32'(exp_byte));
        check_val("count", 32'(count), model_q.size());
        check_val("empty", 32'(empty), 32'(model_q.size() == 0));
        check_val("full", 32'(full), 32'(model_q.size() == DEPTH));
        check_val("overflow", 32'(overflow), 32'(exp_ovf));
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
        check_val("almost_full", 32'(almost_full), 32'(model_q.size() >= DEPTH - 2));
`endif
    endtask

    task automatic model_clear();
        model_q.delete();
        exp_byte  = '0;
        exp_ready = 1'b0;
        exp_ovf   = 1'b0;
    endtask

    task automatic cycle(input logic w, input logic [M-1:0] d, input logic r);
        logic ra, wa;
        @(negedge clk);
        wr_en   = w;
        byte_in = d;
        rd_en   = r;
        ra = r && (model_q.size() > 0);
        wa = w && ((model_q.size() < DEPTH) || ra);
        @(posedge clk);
        #1;
        exp_ready = ra;
        if (ra) exp_byte = model_q.pop_front();
        if (wa) model_q.push_back(d);
        if (w && !wa) exp_ovf = 1'b1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_clear();
        do_reset();

        // 1: idle after reset, then asynchronous reset with entries stored
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0);
        check_val("rst_byte_out", 32'(byte_out), 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b1, M'(8'h10 + i), 1'b0);
        check_val("pre_rst_count", 32'(count), 32'd5);
        #2;
        reset = 1'b0;
        wr_en = 1'b0;
        #1;
        model_clear();
        check_val("async_rst_count", 32'(count), 32'd0);
        check_val("async_rst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);

        // 2: three writes, four read requests
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b1, 8'h0F, 1'b0);
        cycle(1'b0, '0, 1'b1);
        check_val("t2_rd0", 32'(byte_out), 32'hA5);
        cycle(1'b0, '0, 1'b1);
        check_val("t2_rd1", 32'(byte_out), 32'h3C);
        cycle(1'b0, '0, 1'b1);
        check_val("t2_rd2", 32'(byte_out), 32'h0F);
        cycle(1'b0, '0, 1'b1);
        check_val("t2_rd3_ready", 32'(ready_out), 32'd0);
        check_val("t2_empty", 32'(empty), 32'd1);

        // 3: fill, overflow, drain
        for (int i = 0; i < 16; i++) cycle(1'b1, M'(i), 1'b0);
        check_val("t3_full", 32'(full), 32'd1);
        cycle(1'b1, 8'hFF, 1'b0);
        check_val("t3_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, '0, 1'b1);
            check_val("t3_drain", 32'(byte_out), 32'(i));
        end
        check_val("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 4: full with simultaneous read and write
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, M'(i), 1'b0);
        cycle(1'b1, 8'h77, 1'b1);
        check_val("t4_pop", 32'(byte_out), 32'h00);
        check_val("t4_count", 32'(count), 32'd16);
        check_val("t4_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
        check_val("t4_last", 32'(byte_out), 32'h77);

        // 5: empty with simultaneous read and write (no bypass)
        cycle(1'b1, 8'h5A, 1'b1);
        check_val("t5_ready", 32'(ready_out), 32'd0);
        check_val("t5_count", 32'(count), 32'd1);
        cycle(1'b0, '0, 1'b1);
        check_val("t5_byte", 32'(byte_out), 32'h5A);

        // 6: wrap-around pairs, then fill to 14
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, M'(8'h80 + i), 1'b0);
            cycle(1'b0, '0, 1'b1);
            check_val("t6_wrap", 32'(byte_out), 32'(8'h80 + i));
        end
        for (int i = 0; i < 14; i++) cycle(1'b1, M'(8'hC0 + i), 1'b0);
        check_val("t6_count14", 32'(count), 32'd14);
        for (int i = 0; i < 14; i++) cycle(1'b0, '0, 1'b1);

        // Randomized traffic: alternate write-heavy and read-heavy phases to hit both ends
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int unsigned pw;
            pw = ((i / 50) % 2 == 0) ? 80 : 25;
            cycle(($urandom_range(0, 99) < pw), M'($urandom), ($urandom_range(0, 99) >= pw));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
